vga_text_fetch: RTL and testbench
=================================

# vga_text_fetch

Text-mode fetch sequencer and VRAM arbiter for the VGA path. It walks an 80x25 character/attribute frame buffer in step with the sync generator's pixel counters and fetches one 16-bit cell per character. It drives the glyph, row, column, colour and cursor inputs of the font/colour lookup stage. It also shares the single-port VRAM between these display fetches and CPU bus accesses, with the display having priority.

## Interface
Parameters:
- H_TOTAL, 800: pixels per line, including blanking.
- V_TOTAL, 449: lines per frame, including blanking.
- COLS, 80: characters per row. The active width is COLS*8 = 640.
- ROWS, 25: character rows. The active height is ROWS*16 = 400.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- hpos  in  10  current pixel column from the sync generator, 0..H_TOTAL-1
- vpos  in  10  current line from the sync generator, 0..V_TOTAL-1
- start_addr  in  11  word address of the top-left cell (hardware scroll)
- cursor_pos  in  11  cell index of the cursor, relative to start_addr
- cursor_enable  in  1  enables cursor rendering
- blink_enable  in  1  attr[7] selects blink instead of bright background
- glyph  out  8  character code to the font lookup
- glyph_row  out  3  glyph row within the cell
- glyph_col  out  3  pixel column within the glyph
- foreground  out  4  foreground colour index
- background  out  4  background colour index
- render_cursor  out  1  inverts the current glyph pixel
- cpu_req  in  1  CPU access request, held until ack
- cpu_wr_en  in  1  1 = write, 0 = read
- cpu_addr  in  11  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_bytesel  in  2  byte enables for writes
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, valid while cpu_ack=1
- vram_addr  out  11  VRAM word address
- vram_rd_en  out  1  VRAM read strobe
- vram_wr_en  out  1  VRAM write strobe
- vram_wdata  out  16  VRAM write data
- vram_bytesel  out  2  VRAM byte enables
- vram_rdata  in  16  VRAM read data, valid the cycle after vram_rd_en

## Operation
- The active area is hpos<640 and vpos<400.
  - Character row = vpos[9:4].
  - Character column c = hpos[9:3].
  - Each glyph row is displayed on two lines.
- Cell word layout: [7:0] is the character, [15:8] is the attribute.
- Fetch address = start_addr + row*80 + c, modulo 2048.
- Fetch slots are one cycle each and issue only when the target line is active:
  - At hpos = 8c+4 (c = 0..78): fetch cell c+1 of the current line.
  - At hpos = H_TOTAL-4: prefetch cell 0 of the next line. vpos = V_TOTAL-1 targets line 0.
  - start_addr is latched at hpos = H_TOTAL-4 of line V_TOTAL-1 and held for the whole frame.
- Fetched data is captured into a "next" register the cycle after the slot.
- When hpos[2:0]==0 and the position is active, the output registers load:
  - glyph = next[7:0].
  - foreground = attr[3:0].
  - background = blink_enable ? {0, attr[6:4]} : attr[7:4].
- Character blink: if blink_enable, attr[7]=1 and frame_cnt[4]=0, then foreground = background.
- glyph_row = vpos[3:1] and glyph_col = hpos[2:0] are registered every cycle.
- Outside the active area, glyph, foreground, background and render_cursor are forced to 0.
- frame_cnt is 5 bits. It increments on the cycle with hpos=0 and vpos=0 and wraps 31 -> 0.
- render_cursor = cursor_enable & (row*80+c == cursor_pos) & (glyph_row ≥ 6) & frame_cnt[3].
- Arbiter states: IDLE, CPU_ACC.
  - A display slot always wins the port.
  - In IDLE, with cpu_req=1 and no slot this cycle: drive vram_addr/wr_en/rd_en/wdata/bytesel from the CPU, then go to CPU_ACC.
  - In CPU_ACC: pulse cpu_ack. For reads, cpu_rdata = vram_rdata. Return to IDLE.
  - No new CPU grant is made on the ack cycle.

## Timing
- Reset is asynchronous. While reset_n=0, every output is 0 and frame_cnt, next and the arbiter state (IDLE) are cleared.
- Display latency: outputs at cycle t describe the (hpos, vpos) sampled at t-1. The sync generator delays its syncs by 2 cycles to cover this block plus the LUT register.
- VRAM strobes are combinational from the slot/grant decision. vram_rd_en and vram_wr_en are never both 1.
- CPU latency:
  - Best case, ack 1 cycle after the grant cycle.
  - A request colliding with a display slot is granted the next cycle, so worst-case ack is 2 cycles after request.
- A CPU write and a display fetch to the same address in the same cycle: the fetch reads the old value and the write completes afterwards.
- reset_n asserting mid CPU access drops the access without an ack. The CPU reissues the request.
- cpu_req falling before ack is illegal and behaviour is undefined.

## Test plan
- Reset, then free-run one frame with VRAM cell n = {0x07, n[7:0]}, start_addr=0 -> at input hpos=8, vpos=0, the next-cycle glyph=0x01, foreground=7, background=0. Every fetch slot lands at hpos ≡ 4 mod 8 or hpos = 796.
- start_addr=0x7F0 changed mid-frame -> no effect until the next frame. Line 0 cell 20 then fetches address 0x004 (modulo-2048 wrap).
- Hold cpu_req read at addr 0x123 across a display slot -> grant is delayed 1 cycle, cpu_ack arrives 2 cycles after request, cpu_rdata = VRAM[0x123].
- CPU write 0xABCD with bytesel=2'b01 during vertical blank -> VRAM word low byte becomes 0xCD and the high byte is unchanged. Ack 1 cycle after the grant cycle.
- cursor_pos=81, cursor_enable=1, frame_cnt[3]=1 -> render_cursor=1 only for row 1, column 1, glyph_row 6..7 (vpos 28..31, hpos 8..15).
- attr=0x9E, blink_enable=1 -> background=1, foreground=0xE for frames 16..31 and foreground=1 for frames 0..15. Assert reset_n mid-line -> all outputs are 0 immediately.

Source files
------------

// File: rtl/vga_text_fetch_if.sv
// CPU-side VRAM access bus for the text fetch sequencer.
// Request is held until the one-cycle ack pulse.
interface vga_text_fetch_if;
  logic        cpu_req;
  logic        cpu_wr_en;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [1:0]  cpu_bytesel;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;

  modport master (
    output cpu_req,
    output cpu_wr_en,
    output cpu_addr,
    output cpu_wdata,
    output cpu_bytesel,
    input  cpu_ack,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_req,
    input  cpu_wr_en,
    input  cpu_addr,
    input  cpu_wdata,
    input  cpu_bytesel,
    output cpu_ack,
    output cpu_rdata
  );
endinterface

// File: rtl/vga_text_fetch.sv
// Text-mode cell fetch sequencer and VRAM arbiter.
// Display slots own the VRAM port; CPU fills the gaps.
module vga_text_fetch #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 449,
  parameter int COLS    = 80,
  parameter int ROWS    = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic [10:0] start_addr,
  input  logic [10:0] cursor_pos,
  input  logic        cursor_enable,
  input  logic        blink_enable,
  output logic [7:0]  glyph,
  output logic [2:0]  glyph_row,
  output logic [2:0]  glyph_col,
  output logic [3:0]  foreground,
  output logic [3:0]  background,
  output logic        render_cursor,
  vga_text_fetch_if.slave cpu,
  output logic [10:0] vram_addr,
  output logic        vram_rd_en,
  output logic        vram_wr_en,
  output logic [15:0] vram_wdata,
  output logic [1:0]  vram_bytesel,
  input  logic [15:0] vram_rdata
);

  localparam logic [9:0] H_ACT  = 10'(COLS * 8);
  localparam logic [9:0] V_ACT  = 10'(ROWS * 16);
  localparam logic [9:0] H_PRE  = 10'(H_TOTAL - 4);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SEND = 10'((COLS - 1) * 8);

  typedef enum logic {IDLE, CPU_ACC} arb_t;

  arb_t        state, state_nxt;
  logic        wr_q;
  logic [10:0] start_q;
  logic [4:0]  frame_cnt;
  logic [15:0] next;
  logic        slot_d;

  logic        active;
  logic [9:0]  nline;
  logic        cell_slot;
  logic        line_slot;
  logic        slot;
  logic        grant;
  logic        latch_start;
  logic [10:0] base;
  logic [10:0] cell_idx;
  logic [10:0] fetch_addr;
  logic        cursor_hit;
  logic [7:0]  attr;
  logic [3:0]  bg_n;
  logic [3:0]  fg_n;

  function automatic logic [10:0] row_off(
    input logic [5:0] r
  );
    return ({5'b0, r} << 6) + ({5'b0, r} << 4);
  endfunction

  assign active = (hpos < H_ACT) && (vpos < V_ACT);
  assign nline  = (vpos == V_LAST) ? 10'd0
                                   : vpos + 10'd1;

  assign cell_slot = (vpos < V_ACT)
                  && (hpos[2:0] == 3'd4)
                  && (hpos < H_SEND);
  assign line_slot = (hpos == H_PRE)
                  && (nline < V_ACT);
  assign slot      = cell_slot | line_slot;

  // New scroll base applies from the line-0 prefetch onward
  assign latch_start = (hpos == H_PRE)
                    && (vpos == V_LAST);
  assign base = latch_start ? start_addr : start_q;

  assign cell_idx = row_off(vpos[9:4])
                  + {4'b0, hpos[9:3]};

  assign fetch_addr = cell_slot
    ? base + cell_idx + 11'd1
    : base + row_off(nline[9:4]);

  assign cursor_hit = cursor_enable
                   && (cell_idx == cursor_pos)
                   && (vpos[3:1] >= 3'd6)
                   && frame_cnt[3];

  assign attr = next[15:8];
  assign bg_n = blink_enable ? {1'b0, attr[6:4]}
                             : attr[7:4];
  assign fg_n = (blink_enable & attr[7] & ~frame_cnt[4])
              ? bg_n : attr[3:0];

  assign grant = reset_n && (state == IDLE)
              && cpu.cpu_req && !slot;

  always_comb begin
    state_nxt     = state;
    vram_addr     = '0;
    vram_rd_en    = 1'b0;
    vram_wr_en    = 1'b0;
    vram_wdata    = '0;
    vram_bytesel  = '0;
    cpu.cpu_ack   = 1'b0;
    cpu.cpu_rdata = '0;
    unique case (1'b1)
      (slot && reset_n): begin
        vram_addr  = fetch_addr;
        vram_rd_en = 1'b1;
      end
      grant: begin
        vram_addr    = cpu.cpu_addr;
        vram_wr_en   = cpu.cpu_wr_en;
        vram_rd_en   = !cpu.cpu_wr_en;
        vram_wdata   = cpu.cpu_wdata;
        vram_bytesel = cpu.cpu_bytesel;
      end
      default: ;
    endcase
    unique case (state)
      IDLE: begin
        if (grant) state_nxt = CPU_ACC;
      end
      CPU_ACC: begin
        cpu.cpu_ack = 1'b1;
        if (!wr_q) cpu.cpu_rdata = vram_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_q          <= 1'b0;
      start_q       <= '0;
      frame_cnt     <= '0;
      next          <= '0;
      slot_d        <= 1'b0;
      glyph         <= '0;
      glyph_row     <= '0;
      glyph_col     <= '0;
      foreground    <= '0;
      background    <= '0;
      render_cursor <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot_d    <= slot;
      glyph_row <= vpos[3:1];
      glyph_col <= hpos[2:0];
      if (grant) wr_q <= cpu.cpu_wr_en;
      if (latch_start) start_q <= start_addr;
      if (hpos == 10'd0 && vpos == 10'd0)
        frame_cnt <= frame_cnt + 5'd1;
      if (slot_d) next <= vram_rdata;
      if (!active) begin
        glyph         <= '0;
        foreground    <= '0;
        background    <= '0;
        render_cursor <= 1'b0;
      end else begin
        render_cursor <= cursor_hit;
        if (hpos[2:0] == 3'd0) begin
          glyph      <= next[7:0];
          foreground <= fg_n;
          background <= bg_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_text_fetch.sv
// Directed bench for vga_text_fetch with a behavioural VRAM.
// Each task drives a scenario and checks against hand values.
module tb_vga_text_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  hpos, vpos;
  logic [10:0] start_addr, cursor_pos;
  logic        cursor_enable, blink_enable;
  logic [7:0]  glyph;
  logic [2:0]  glyph_row, glyph_col;
  logic [3:0]  foreground, background;
  logic        render_cursor;
  logic [10:0] vram_addr;
  logic        vram_rd_en, vram_wr_en;
  logic [15:0] vram_wdata;
  logic [1:0]  vram_bytesel;
  logic [15:0] vram_rdata;

  logic [15:0] mem [0:2047];
  int n_cmp = 0;
  int n_bad = 0;

  vga_text_fetch_if cpu_bus();

  always #5 clk = ~clk;

  vga_text_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hpos          (hpos),
    .vpos          (vpos),
    .start_addr    (start_addr),
    .cursor_pos    (cursor_pos),
    .cursor_enable (cursor_enable),
    .blink_enable  (blink_enable),
    .glyph         (glyph),
    .glyph_row     (glyph_row),
    .glyph_col     (glyph_col),
    .foreground    (foreground),
    .background    (background),
    .render_cursor (render_cursor),
    .cpu           (cpu_bus),
    .vram_addr     (vram_addr),
    .vram_rd_en    (vram_rd_en),
    .vram_wr_en    (vram_wr_en),
    .vram_wdata    (vram_wdata),
    .vram_bytesel  (vram_bytesel),
    .vram_rdata    (vram_rdata)
  );

  always @(posedge clk) begin
    if (vram_wr_en) begin
      if (vram_bytesel[0])
        mem[vram_addr][7:0] = vram_wdata[7:0];
      if (vram_bytesel[1])
        mem[vram_addr][15:8] = vram_wdata[15:8];
    end
    if (vram_rd_en) vram_rdata <= mem[vram_addr];
  end

  task automatic drive(input int h, input int v);
    @(negedge clk);
    hpos = 10'(h);
    vpos = 10'(v);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int h, input int v);
    drive(h, v);
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    hpos = 10'd700;
    vpos = 10'd420;
    cpu_bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    hpos = 10'd4;
    vpos = 10'd0;
    cpu_bus.cpu_req = 1'b1;
    cpu_bus.cpu_wr_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if ({glyph, foreground, background,
         render_cursor} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_disp: got %h/%h/%h/%b want 0",
               glyph, foreground, background,
               render_cursor);
    end
    n_cmp++;
    if ({glyph_row, glyph_col} !== 6'h0) begin
      n_bad++;
      $display("FAIL reset_rowcol: got %h %h want 0",
               glyph_row, glyph_col);
    end
    n_cmp++;
    if ({vram_rd_en, vram_wr_en, vram_addr,
         vram_wdata, vram_bytesel} !== 31'h0) begin
      n_bad++;
      $display("FAIL reset_vram: rd %b wr %b addr %h want 0",
               vram_rd_en, vram_wr_en, vram_addr);
    end
    n_cmp++;
    if ({cpu_bus.cpu_ack, cpu_bus.cpu_rdata} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_cpu: ack %b rdata %h want 0",
               cpu_bus.cpu_ack, cpu_bus.cpu_rdata);
    end
    cpu_bus.cpu_req = 1'b0;
    cpu_bus.cpu_wr_en = 1'b0;
    hpos = 10'd700;
    vpos = 10'd420;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fetch_lines();
    int lines [3] = '{448, 0, 399};
    int want_slots [3] = '{1, 80, 79};
    for (int li = 0; li < 3; li++) begin
      int v = lines[li];
      int slots = 0;
      for (int h = 0; h < 800; h++) begin
        bit exp_slot = 1'b0;
        int exp_addr = 0;
        if (v < 400 && h % 8 == 4 && h < 632) begin
          exp_slot = 1'b1;
          exp_addr = ((v / 16) * 80 + h / 8 + 1) % 2048;
        end
        if (h == 796) begin
          int nl = (v == 448) ? 0 : v + 1;
          if (nl < 400) begin
            exp_slot = 1'b1;
            exp_addr = ((nl / 16) * 80) % 2048;
          end
        end
        drive(h, v);
        n_cmp++;
        if (vram_rd_en !== exp_slot) begin
          n_bad++;
          $display("FAIL slot_pos v%0d h%0d: rd %b want %b",
                   v, h, vram_rd_en, exp_slot);
        end
        if (exp_slot) begin
          n_cmp++;
          if (vram_addr !== 11'(exp_addr)) begin
            n_bad++;
            $display("FAIL slot_addr v%0d h%0d: %h want %h",
                     v, h, vram_addr, 11'(exp_addr));
          end
        end
        if (vram_rd_en) slots++;
        tick();
        if (v == 0 && h == 0) begin
          n_cmp++;
          if ({glyph, foreground} !== 12'h007) begin
            n_bad++;
            $display("FAIL cell0: got %h %h want 00 7",
                     glyph, foreground);
          end
        end
        if (v == 0 && h == 8) begin
          n_cmp++;
          if ({glyph, foreground, background}
              !== 16'h0170) begin
            n_bad++;
            $display("FAIL cell1: got %h %h %h want 01 7 0",
                     glyph, foreground, background);
          end
        end
        if (v == 0 && h == 632) begin
          n_cmp++;
          if (glyph !== 8'h4F) begin
            n_bad++;
            $display("FAIL cell79: got %h want 4f", glyph);
          end
        end
        if (v == 399 && h == 8) begin
          n_cmp++;
          if ({glyph, foreground} !== 12'h817) begin
            n_bad++;
            $display("FAIL row24: got %h %h want 81 7",
                     glyph, foreground);
          end
        end
        if (v == 448 && h == 8) begin
          n_cmp++;
          if ({glyph, foreground} !== 12'h000) begin
            n_bad++;
            $display("FAIL blank: got %h %h want 0",
                     glyph, foreground);
          end
        end
      end
      n_cmp++;
      if (slots != want_slots[li]) begin
        n_bad++;
        $display("FAIL slot_count v%0d: %0d want %0d",
                 v, slots, want_slots[li]);
      end
    end
  endtask

  task automatic test_scroll();
    start_addr = 11'h7F0;
    drive(4, 16);
    n_cmp++;
    if (vram_addr !== 11'd81) begin
      n_bad++;
      $display("FAIL scroll_hold: %h want 051", vram_addr);
    end
    tick();
    drive(796, 448);
    n_cmp++;
    if (vram_addr !== 11'h7F0) begin
      n_bad++;
      $display("FAIL scroll_latch: %h want 7f0", vram_addr);
    end
    tick();
    drive(156, 0);
    n_cmp++;
    if (vram_addr !== 11'h004) begin
      n_bad++;
      $display("FAIL scroll_wrap: %h want 004", vram_addr);
    end
    tick();
    start_addr = 11'h000;
    step(796, 448);
  endtask

  task automatic test_cpu_read_collision();
    @(negedge clk);
    hpos = 10'd4;
    vpos = 10'd0;
    cpu_bus.cpu_req = 1'b1;
    cpu_bus.cpu_wr_en = 1'b0;
    cpu_bus.cpu_addr = 11'h123;
    #1;
    n_cmp++;
    if ({vram_rd_en, vram_addr, cpu_bus.cpu_ack}
        !== {1'b1, 11'h001, 1'b0}) begin
      n_bad++;
      $display("FAIL coll_slot: rd %b addr %h ack %b want 1 001 0",
               vram_rd_en, vram_addr, cpu_bus.cpu_ack);
    end
    tick();
    drive(5, 0);
    n_cmp++;
    if ({vram_rd_en, vram_wr_en, vram_addr,
         cpu_bus.cpu_ack}
        !== {1'b1, 1'b0, 11'h123, 1'b0}) begin
      n_bad++;
      $display("FAIL coll_grant: rd %b wr %b addr %h ack %b",
               vram_rd_en, vram_wr_en, vram_addr,
               cpu_bus.cpu_ack);
    end
    tick();
    drive(6, 0);
    n_cmp++;
    if ({cpu_bus.cpu_ack, cpu_bus.cpu_rdata}
        !== {1'b1, 16'h0723}) begin
      n_bad++;
      $display("FAIL coll_ack: ack %b rdata %h want 1 0723",
               cpu_bus.cpu_ack, cpu_bus.cpu_rdata);
    end
    n_cmp++;
    if ({vram_rd_en, vram_wr_en} !== 2'b00) begin
      n_bad++;
      $display("FAIL ack_nogrant: rd %b wr %b want 0 0",
               vram_rd_en, vram_wr_en);
    end
    tick();
    cpu_bus.cpu_req = 1'b0;
    drive(7, 0);
    n_cmp++;
    if (cpu_bus.cpu_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_pulse: ack %b want 0",
               cpu_bus.cpu_ack);
    end
    tick();
  endtask

  task automatic test_cpu_write();
    @(negedge clk);
    hpos = 10'd100;
    vpos = 10'd420;
    cpu_bus.cpu_req = 1'b1;
    cpu_bus.cpu_wr_en = 1'b1;
    cpu_bus.cpu_addr = 11'h050;
    cpu_bus.cpu_wdata = 16'hABCD;
    cpu_bus.cpu_bytesel = 2'b01;
    #1;
    n_cmp++;
    if ({vram_wr_en, vram_rd_en, vram_addr, vram_wdata,
         vram_bytesel}
        !== {1'b1, 1'b0, 11'h050, 16'hABCD, 2'b01}) begin
      n_bad++;
      $display("FAIL wr_grant: wr %b rd %b addr %h d %h be %b",
               vram_wr_en, vram_rd_en, vram_addr,
               vram_wdata, vram_bytesel);
    end
    tick();
    drive(101, 420);
    n_cmp++;
    if ({cpu_bus.cpu_ack, cpu_bus.cpu_rdata, vram_wr_en}
        !== {1'b1, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL wr_ack: ack %b rdata %h wr %b want 1 0 0",
               cpu_bus.cpu_ack, cpu_bus.cpu_rdata, vram_wr_en);
    end
    tick();
    cpu_bus.cpu_req = 1'b0;
    cpu_bus.cpu_wr_en = 1'b0;
    n_cmp++;
    if (mem[11'h050] !== 16'h07CD) begin
      n_bad++;
      $display("FAIL wr_bytes: mem %h want 07cd",
               mem[11'h050]);
    end
  endtask

  task automatic test_cursor();
    int hs [6] = '{8, 15, 16, 8, 7, 8};
    int vs [6] = '{28, 31, 28, 27, 28, 28};
    bit ex [6] = '{1, 1, 0, 0, 0, 0};
    do_reset();
    cursor_pos = 11'd81;
    cursor_enable = 1'b1;
    repeat (8) step(0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) cursor_enable = 1'b0;
      step(hs[i], vs[i]);
      n_cmp++;
      if (render_cursor !== ex[i]) begin
        n_bad++;
        $display("FAIL cursor h%0d v%0d: %b want %b",
                 hs[i], vs[i], render_cursor, ex[i]);
      end
    end
    step(15, 31);
    n_cmp++;
    if ({glyph_row, glyph_col} !== 6'o77) begin
      n_bad++;
      $display("FAIL rowcol: %0d %0d want 7 7",
               glyph_row, glyph_col);
    end
  endtask

  task automatic test_blink();
    mem[1] = 16'h9E41;
    blink_enable = 1'b1;
    step(4, 0);
    step(5, 0);
    step(8, 0);
    n_cmp++;
    if ({glyph, foreground, background} !== 16'h4111) begin
      n_bad++;
      $display("FAIL blink_off: %h %h %h want 41 1 1",
               glyph, foreground, background);
    end
    repeat (8) step(0, 0);
    step(8, 0);
    n_cmp++;
    if ({foreground, background} !== 8'hE1) begin
      n_bad++;
      $display("FAIL blink_on: %h %h want e 1",
               foreground, background);
    end
    cursor_enable = 1'b1;
    step(8, 28);
    n_cmp++;
    if (render_cursor !== 1'b0) begin
      n_bad++;
      $display("FAIL cursor_phase: %b want 0",
               render_cursor);
    end
    cursor_enable = 1'b0;
    blink_enable = 1'b0;
    step(8, 0);
    n_cmp++;
    if ({foreground, background} !== 8'hE9) begin
      n_bad++;
      $display("FAIL bright_bg: %h %h want e 9",
               foreground, background);
    end
    step(700, 0);
    n_cmp++;
    if ({glyph, foreground, background} !== 16'h0) begin
      n_bad++;
      $display("FAIL inactive: %h %h %h want 0",
               glyph, foreground, background);
    end
  endtask

  task automatic test_reset_midline();
    blink_enable = 1'b1;
    step(8, 0);
    n_cmp++;
    if ({foreground, background} !== 8'hE1) begin
      n_bad++;
      $display("FAIL pre_reset: %h %h want e 1",
               foreground, background);
    end
    @(negedge clk);
    hpos = 10'd9;
    cpu_bus.cpu_req = 1'b1;
    cpu_bus.cpu_wr_en = 1'b0;
    cpu_bus.cpu_addr = 11'h010;
    #1;
    n_cmp++;
    if ({vram_rd_en, vram_addr} !== {1'b1, 11'h010}) begin
      n_bad++;
      $display("FAIL rst_grant: rd %b addr %h want 1 010",
               vram_rd_en, vram_addr);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({glyph, foreground, background,
         render_cursor} !== 17'h0) begin
      n_bad++;
      $display("FAIL rst_async: %h %h %h %b want 0",
               glyph, foreground, background, render_cursor);
    end
    n_cmp++;
    if ({cpu_bus.cpu_ack, vram_rd_en, vram_wr_en}
        !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_drop: ack %b rd %b wr %b want 0",
               cpu_bus.cpu_ack, vram_rd_en, vram_wr_en);
    end
    @(negedge clk);
    cpu_bus.cpu_req = 1'b0;
    reset_n = 1'b1;
    drive(10, 0);
    n_cmp++;
    if (cpu_bus.cpu_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_noack: ack %b want 0",
               cpu_bus.cpu_ack);
    end
    tick();
  endtask

  initial begin
    for (int n = 0; n < 2048; n++)
      mem[n] = {8'h07, 8'(n)};
    vram_rdata = '0;
    reset_n = 1'b0;
    hpos = '0;
    vpos = '0;
    start_addr = '0;
    cursor_pos = '0;
    cursor_enable = 1'b0;
    blink_enable = 1'b0;
    cpu_bus.cpu_req = 1'b0;
    cpu_bus.cpu_wr_en = 1'b0;
    cpu_bus.cpu_addr = '0;
    cpu_bus.cpu_wdata = '0;
    cpu_bus.cpu_bytesel = '0;
    test_reset();
    test_fetch_lines();
    test_scroll();
    test_cpu_read_collision();
    test_cpu_write();
    test_cursor();
    test_blink();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
